// File: rtl/mips_mc_ctrl_pkg.sv
// mips_mc_ctrl_pkg: shared encodings for the multicycle MIPS control unit
// (instruction fields, FSM states, ALU operation codes, datapath select codes).
package mips_mc_ctrl_pkg;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'd0,
      OP_J     = 6'd2,
      OP_JAL   = 6'd3,
      OP_BEQ   = 6'd4,
      OP_BNE   = 6'd5,
      OP_ADDI  = 6'd8,
      OP_LW    = 6'd35,
      OP_SW    = 6'd43
   } opcode_t;

   typedef enum logic [5:0] {
      F_ADD = 6'd32,
      F_SUB = 6'd34,
      F_AND = 6'd36,
      F_OR  = 6'd37,
      F_XOR = 6'd38,
      F_NOR = 6'd39,
      F_SLT = 6'd42
   } funct_t;

   // FETCH must stay at zero: the reset-forced state_o reads as FETCH
   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11,
      S_ILLEGAL = 4'd12,
      S_JAL     = 4'd13
   } state_t;

   typedef enum logic [2:0] {
      ALU_AND = 3'd0,
      ALU_OR  = 3'd1,
      ALU_ADD = 3'd2,
      ALU_XOR = 3'd3,
      ALU_NOR = 3'd4,
      ALU_SUB = 3'd6,
      ALU_SLT = 3'd7
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      AOP_ADD   = 2'd0,
      AOP_SUB   = 2'd1,
      AOP_FUNCT = 2'd2
   } alu_op_t;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [1:0] REG_DST_RT    = 2'b00;
   localparam logic [1:0] REG_DST_RD    = 2'b01;
   localparam logic [1:0] REG_DST_RA    = 2'b10;
   localparam logic [1:0] M2R_ALUOUT    = 2'b00;
   localparam logic [1:0] M2R_MDR       = 2'b01;
   localparam logic [1:0] M2R_PC        = 2'b10;
   localparam logic [1:0] SRCB_B        = 2'b00;
   localparam logic [1:0] SRCB_4        = 2'b01;
   localparam logic [1:0] SRCB_IMM      = 2'b10;
   localparam logic [1:0] SRCB_IMM_SL2  = 2'b11;

endpackage

// File: rtl/mips_mc_ctrl_aludec.sv
// mips_mc_aludec: ALU control decode from the FSM's ALU operation class and the
// R-type funct field; also flags whether funct is a supported R-type operation.
module mips_mc_aludec
   import mips_mc_ctrl_pkg::*;
(
   input  funct_t    funct,
   input  alu_op_t   op,
   output alu_ctrl_t alu_ctrl,
   output logic      funct_legal
);

   alu_ctrl_t fctrl;

   always_comb begin
      fctrl = ALU_ADD;
      funct_legal = 1'b1;
      case (funct)
         F_ADD:   fctrl = ALU_ADD;
         F_SUB:   fctrl = ALU_SUB;
         F_AND:   fctrl = ALU_AND;
         F_OR:    fctrl = ALU_OR;
         F_XOR:   fctrl = ALU_XOR;
         F_NOR:   fctrl = ALU_NOR;
         F_SLT:   fctrl = ALU_SLT;
         default: funct_legal = 1'b0;
      endcase
      alu_ctrl = (op == AOP_FUNCT) ? fctrl : (op == AOP_SUB) ? ALU_SUB : ALU_ADD;
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS control FSM driving the shared ALU, unified memory port,
// register file and PC. Define MIPS_MC_CTRL_JAL_EN to support JAL.
module mips_mc_ctrl
   import mips_mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_en,
   output logic [1:0] pc_src,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic       illegal,
   output logic [3:0] state_o
);

   state_t    state, nxt;
   opcode_t   op;
   funct_t    fn;
   alu_op_t   alu_op;
   alu_ctrl_t dec_ctrl;
   logic      funct_legal;

   assign op = opcode_t'(opcode);
   assign fn = funct_t'(funct);

   mips_mc_aludec u_aludec (
      .funct       (fn),
      .op          (alu_op),
      .alu_ctrl    (dec_ctrl),
      .funct_legal (funct_legal)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_FETCH;
      else        state <= nxt;

   // Every output is state-decoded and held at zero while reset is asserted
   always_comb begin
      nxt        = state;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_src     = PC_SRC_ALU;
      reg_write  = 1'b0;
      reg_dst    = REG_DST_RT;
      mem_to_reg = M2R_ALUOUT;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_op     = AOP_ADD;
      illegal    = 1'b0;
      if (rst_n) begin
         case (state)
            S_FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = SRCB_4;
               ir_write  = mem_ready;
               pc_en     = mem_ready;
               nxt       = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
               alu_src_b = SRCB_IMM_SL2;
               case (op)
                  OP_LW, OP_SW:   nxt = S_MEMADR;
                  OP_RTYPE:       nxt = S_EXEC;
                  OP_BEQ, OP_BNE: nxt = S_BRANCH;
                  OP_ADDI:        nxt = S_ADDIEX;
                  OP_J:           nxt = S_JUMP;
`ifdef MIPS_MC_CTRL_JAL_EN
                  OP_JAL:         nxt = S_JAL;
`else
                  OP_JAL:         nxt = S_ILLEGAL;
`endif
                  default:        nxt = S_ILLEGAL;
               endcase
            end
            S_MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
               nxt       = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
               nxt     = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = M2R_MDR;
               nxt        = S_FETCH;
            end
            S_MEMWR: begin
               mem_req   = 1'b1;
               mem_write = 1'b1;
               iord      = 1'b1;
               nxt       = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = AOP_FUNCT;
               nxt       = funct_legal ? S_ALUWB : S_ILLEGAL;
            end
            S_ALUWB: begin
               reg_write = 1'b1;
               reg_dst   = REG_DST_RD;
               nxt       = S_FETCH;
            end
            S_BRANCH: begin
               alu_src_a = 1'b1;
               alu_op    = AOP_SUB;
               pc_src    = PC_SRC_ALUOUT;
               pc_en     = (op == OP_BNE) ? ~zero : zero;
               nxt       = S_FETCH;
            end
            S_ADDIEX: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
               nxt       = S_ADDIWB;
            end
            S_ADDIWB: begin
               reg_write = 1'b1;
               nxt       = S_FETCH;
            end
            S_JUMP: begin
               pc_src = PC_SRC_JUMP;
               pc_en  = 1'b1;
               nxt    = S_FETCH;
            end
            S_ILLEGAL: begin
               illegal = 1'b1;
               nxt     = S_FETCH;
            end
`ifdef MIPS_MC_CTRL_JAL_EN
            S_JAL: begin
               reg_write  = 1'b1;
               reg_dst    = REG_DST_RA;
               mem_to_reg = M2R_PC;
               pc_src     = PC_SRC_JUMP;
               pc_en      = 1'b1;
               nxt        = S_FETCH;
            end
`endif
            default: nxt = S_FETCH;
         endcase
      end
   end

   assign alu_ctrl = rst_n ? dec_ctrl : 3'd0;
   assign state_o  = state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed instruction sequences; expected per-cycle outputs are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_mips_mc_ctrl;
   import mips_mc_ctrl_pkg::*;

   logic       clk, rst_n, zero, mem_ready;
   logic [5:0] opcode, funct;
   logic       mem_req, mem_write, iord, ir_write, pc_en, reg_write, alu_src_a, illegal;
   logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
   logic [2:0] alu_ctrl;
   logic [3:0] state_o;

   typedef struct packed {
      logic       mem_req, mem_write, iord, ir_write, pc_en;
      logic [1:0] pc_src;
      logic       reg_write;
      logic [1:0] reg_dst, mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_ctrl;
      logic       illegal;
      logic [3:0] state;
   } ov_t;

   typedef struct {
      string nm;
      ov_t   e;
      ov_t   m;
   } exp_t;

   exp_t q[$];
   exp_t x;
   ov_t  act;
   int   ntests = 0;
   int   nfail  = 0;

   mips_mc_ctrl dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
      .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .illegal(illegal), .state_o(state_o)
   );

   assign act = {mem_req, mem_write, iord, ir_write, pc_en, pc_src, reg_write, reg_dst,
                 mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, illegal, state_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk)
      if (q.size() != 0) begin
         x = q.pop_front();
         ntests++;
         if (((act ^ x.e) & x.m) != '0) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (care mask %h)", x.nm, act, x.e, x.m);
         end
      end

   task automatic step(input string nm, input state_t s, input logic mr = 1'b0,
                       input logic z = 1'b0, input logic pe = 1'b0,
                       input logic [2:0] ac = ALU_ADD, input logic acdc = 1'b0);
      ov_t e, m;
      mem_ready = mr;
      zero      = z;
      e = '0;
      e.state = s;
      case (s)
         S_FETCH: begin
            e.mem_req = 1'b1; e.alu_src_b = SRCB_4; e.alu_ctrl = ALU_ADD;
            e.pc_src = PC_SRC_ALU; e.ir_write = mr; e.pc_en = mr;
         end
         S_DECODE: begin e.alu_src_b = SRCB_IMM_SL2; e.alu_ctrl = ALU_ADD; end
         S_MEMADR: begin e.alu_src_a = 1'b1; e.alu_src_b = SRCB_IMM; e.alu_ctrl = ALU_ADD; end
         S_MEMRD:  begin e.mem_req = 1'b1; e.iord = 1'b1; end
         S_MEMWB:  begin e.reg_write = 1'b1; e.reg_dst = REG_DST_RT; e.mem_to_reg = M2R_MDR; end
         S_MEMWR:  begin e.mem_req = 1'b1; e.mem_write = 1'b1; e.iord = 1'b1; end
         S_EXEC:   begin e.alu_src_a = 1'b1; e.alu_src_b = SRCB_B; e.alu_ctrl = ac; end
         S_ALUWB:  begin e.reg_write = 1'b1; e.reg_dst = REG_DST_RD; e.mem_to_reg = M2R_ALUOUT; end
         S_BRANCH: begin
            e.alu_src_a = 1'b1; e.alu_src_b = SRCB_B; e.alu_ctrl = ALU_SUB;
            e.pc_src = PC_SRC_ALUOUT; e.pc_en = pe;
         end
         S_ADDIEX: begin e.alu_src_a = 1'b1; e.alu_src_b = SRCB_IMM; e.alu_ctrl = ALU_ADD; end
         S_ADDIWB: begin e.reg_write = 1'b1; e.reg_dst = REG_DST_RT; e.mem_to_reg = M2R_ALUOUT; end
         S_JUMP:   begin e.pc_src = PC_SRC_JUMP; e.pc_en = 1'b1; end
         S_ILLEGAL: e.illegal = 1'b1;
         S_JAL: begin
            e.reg_write = 1'b1; e.reg_dst = REG_DST_RA; e.mem_to_reg = M2R_PC;
            e.pc_src = PC_SRC_JUMP; e.pc_en = 1'b1;
         end
         default: ;
      endcase
      m = '1;
      if (!(s inside {S_FETCH, S_DECODE, S_MEMADR, S_EXEC, S_BRANCH, S_ADDIEX})) begin
         m.alu_src_a = 1'b0; m.alu_src_b = 2'b0; m.alu_ctrl = 3'b0;
      end
      if (!(s inside {S_FETCH, S_BRANCH, S_JUMP, S_JAL})) m.pc_src = 2'b0;
      if (!e.reg_write) begin m.reg_dst = 2'b0; m.mem_to_reg = 2'b0; end
      if (!e.mem_req) m.iord = 1'b0;
      if (acdc) m.alu_ctrl = 3'b0;
      q.push_back('{nm, e, m});
      @(posedge clk); #1;
   endtask

   task automatic rst_step(input string nm);
      ov_t z0, all;
      z0  = '0;
      all = '1;
      q.push_back('{nm, z0, all});
      @(posedge clk); #1;
   endtask

   task automatic ins(input logic [5:0] o, input logic [5:0] f = 6'd0);
      opcode = o;
      funct  = f;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 6'd0; funct = 6'd0;
      repeat (2) @(posedge clk);
      #1;
      rst_step("reset_idle");
      rst_n = 1'b1;
      ins(6'd35);
      step("lw_fetch", S_FETCH, 1'b1);
      step("lw_decode", S_DECODE);
      step("lw_memadr", S_MEMADR);
      step("lw_memrd", S_MEMRD, 1'b1);
      step("lw_memwb", S_MEMWB);
      ins(6'd0, 6'd32);
      step("fetch_wait0", S_FETCH, 1'b0);
      step("fetch_wait1", S_FETCH, 1'b0);
      step("fetch_wait2", S_FETCH, 1'b0);
      step("fetch_done", S_FETCH, 1'b1);
      step("add_decode", S_DECODE);
      step("add_exec", S_EXEC, 1'b1, 1'b0, 1'b0, ALU_ADD);
      step("add_aluwb", S_ALUWB, 1'b1);
      ins(6'd43);
      step("sw_fetch", S_FETCH, 1'b1);
      step("sw_decode", S_DECODE, 1'b1);
      step("sw_memadr", S_MEMADR);
      step("sw_memwr_wait", S_MEMWR, 1'b0);
      step("sw_memwr", S_MEMWR, 1'b1);
      ins(6'd4);
      step("beq_fetch", S_FETCH, 1'b1);
      step("beq_decode", S_DECODE);
      step("beq_taken", S_BRANCH, 1'b0, 1'b1, 1'b1);
      ins(6'd4);
      step("beq2_fetch", S_FETCH, 1'b1);
      step("beq2_decode", S_DECODE);
      step("beq_not_taken", S_BRANCH, 1'b0, 1'b0, 1'b0);
      ins(6'd5);
      step("bne_fetch", S_FETCH, 1'b1);
      step("bne_decode", S_DECODE);
      step("bne_zero1", S_BRANCH, 1'b0, 1'b1, 1'b0);
      ins(6'd5);
      step("bne2_fetch", S_FETCH, 1'b1);
      step("bne2_decode", S_DECODE);
      step("bne_zero0", S_BRANCH, 1'b0, 1'b0, 1'b1);
      ins(6'd0, 6'd42);
      step("slt_fetch", S_FETCH, 1'b1);
      step("slt_decode", S_DECODE);
      step("slt_exec", S_EXEC, 1'b0, 1'b0, 1'b0, ALU_SLT);
      step("slt_aluwb", S_ALUWB);
      ins(6'd0, 6'd34);
      step("sub_fetch", S_FETCH, 1'b1);
      step("sub_decode", S_DECODE);
      step("sub_exec", S_EXEC, 1'b0, 1'b0, 1'b0, ALU_SUB);
      step("sub_aluwb", S_ALUWB);
      ins(6'd0, 6'd39);
      step("nor_fetch", S_FETCH, 1'b1);
      step("nor_decode", S_DECODE);
      step("nor_exec", S_EXEC, 1'b0, 1'b0, 1'b0, ALU_NOR);
      step("nor_aluwb", S_ALUWB);
      ins(6'd8);
      step("addi_fetch", S_FETCH, 1'b1);
      step("addi_decode", S_DECODE);
      step("addi_ex", S_ADDIEX);
      step("addi_wb", S_ADDIWB);
      ins(6'd2);
      step("j_fetch", S_FETCH, 1'b1);
      step("j_decode", S_DECODE);
      step("j_jump", S_JUMP);
      ins(6'd63);
      step("op63_fetch", S_FETCH, 1'b1);
      step("op63_decode", S_DECODE);
      step("op63_illegal", S_ILLEGAL);
      ins(6'd0, 6'd0);
      step("f0_fetch", S_FETCH, 1'b1);
      step("f0_decode", S_DECODE);
      step("f0_exec", S_EXEC, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b1);
      step("f0_illegal", S_ILLEGAL);
      ins(6'd3);
      step("jal_fetch", S_FETCH, 1'b1);
      step("jal_decode", S_DECODE);
`ifdef MIPS_MC_CTRL_JAL_EN
      step("jal_exec", S_JAL);
`else
      step("jal_illegal", S_ILLEGAL);
`endif
      ins(6'd35);
      step("rlw_fetch", S_FETCH, 1'b1);
      step("rlw_decode", S_DECODE);
      step("rlw_memadr", S_MEMADR);
      step("rlw_memrd_wait0", S_MEMRD, 1'b0);
      step("rlw_memrd_wait1", S_MEMRD, 1'b0);
      rst_n = 1'b0;
      rst_step("reset_mid_memrd0");
      mem_ready = 1'b1;
      rst_step("reset_mid_memrd1");
      rst_n = 1'b1;
      step("post_reset_fetch_wait", S_FETCH, 1'b0);
      step("post_reset_fetch", S_FETCH, 1'b1);
      step("post_reset_decode", S_DECODE);
      step("post_reset_memadr", S_MEMADR);
      step("post_reset_memrd", S_MEMRD, 1'b1);
      step("post_reset_memwb", S_MEMWB);
      step("next_fetch", S_FETCH, 1'b0);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         nfail++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
